// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants and payload types.
// The opcode decoder uses the same constants.
package rv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned F7_W   = 7;
    localparam int unsigned IMM_W  = 13;
    localparam int unsigned OPC_W  = 7;
    localparam int unsigned CNT_W  = 16;

    localparam logic [OPC_W-1:0] OPC_R = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_I = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_L = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_S = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_B = 7'b1100011;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Request type is a raw field: codes 5-7 can arrive and must be flagged.
    typedef logic [TYPE_W-1:0] req_type_t;
    localparam req_type_t REQ_R = 3'd0;
    localparam req_type_t REQ_I = 3'd1;
    localparam req_type_t REQ_L = 3'd2;
    localparam req_type_t REQ_S = 3'd3;
    localparam req_type_t REQ_B = 3'd4;

    typedef struct packed {
        req_type_t         req_type;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [F3_W-1:0]   funct3;
        logic [F7_W-1:0]   funct7;
        logic [IMM_W-1:0]  imm;
    } enc_req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } enc_state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Request-side and memory-write-side bundle of the instruction encoder.
// slave = encoder, master = loader driving requests and accepting writes.
interface instr_encoder_if
    import rv_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) ();

    logic              start_i;
    logic [ADDR_W-1:0] start_addr_i;
    logic              stop_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [TYPE_W-1:0] req_type_i;
    logic [REG_W-1:0]  rd_i;
    logic [REG_W-1:0]  rs1_i;
    logic [REG_W-1:0]  rs2_i;
    logic [F3_W-1:0]   funct3_i;
    logic [F7_W-1:0]   funct7_i;
    logic [IMM_W-1:0]  imm_i;
    logic              wr_valid_o;
    logic              wr_ready_i;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [XLEN-1:0]   wr_data_o;
    logic              err_o;
    logic              done_o;
    logic [CNT_W-1:0]  count_o;

    modport slave (
        input  start_i, start_addr_i, stop_i, req_valid_i, req_type_i,
               rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, wr_ready_i,
        output req_ready_o, wr_valid_o, wr_addr_o, wr_data_o, err_o, done_o, count_o
    );

    modport master (
        output start_i, start_addr_i, stop_i, req_valid_i, req_type_i,
               rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, wr_ready_i,
        input  req_ready_o, wr_valid_o, wr_addr_o, wr_data_o, err_o, done_o, count_o
    );

endinterface

// File: rtl/instr_asm.sv
// Combinational RV32I word assembler sitting between pipeline stages S1 and S2.
// Illegal types yield a NOP; out-of-range immediates are truncated and flagged.
module instr_asm
    import rv_pkg::*;
(
    input  enc_req_t        req_i,
    output logic [XLEN-1:0] word_o,
    output logic            err_o
);

    always_comb begin
        word_o = NOP_INSTR;
        err_o  = 1'b0;
        case (req_i.req_type)
            REQ_R: word_o = {req_i.funct7, req_i.rs2, req_i.rs1, req_i.funct3, req_i.rd, OPC_R};
            REQ_I: begin
                word_o = {req_i.imm[11:0], req_i.rs1, req_i.funct3, req_i.rd, OPC_I};
                err_o  = req_i.imm[12] ^ req_i.imm[11];
            end
            REQ_L: begin
                word_o = {req_i.imm[11:0], req_i.rs1, req_i.funct3, req_i.rd, OPC_L};
                err_o  = req_i.imm[12] ^ req_i.imm[11];
            end
            REQ_S: begin
                word_o = {req_i.imm[11:5], req_i.rs2, req_i.rs1, req_i.funct3,
                          req_i.imm[4:0], OPC_S};
                err_o  = req_i.imm[12] ^ req_i.imm[11];
            end
            REQ_B: begin
                word_o = {req_i.imm[12], req_i.imm[10:5], req_i.rs2, req_i.rs1, req_i.funct3,
                          req_i.imm[4:1], req_i.imm[11], OPC_B};
                err_o  = req_i.imm[0];
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential RV32I instruction assembler: two-stage pipeline streaming words to imem.
// Optional INSTR_ENC_COUNT_EN adds a saturating count of completed writes on count_o.
module instr_encoder
    import rv_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic           clk_i,
    input  logic           rst_i,
    instr_encoder_if.slave bus
);

    enc_state_e        state_q, state_d;
    enc_req_t          s1_q, s1_d;
    logic              s1_vld_q, s1_vld_d;
    logic [XLEN-1:0]   s2_data_q, s2_data_d;
    logic              s2_vld_q, s2_vld_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    enc_req_t          req_in;
    logic [XLEN-1:0]   asm_word;
    logic              asm_err;
    logic              s2_load_ok, s1_adv, req_ready, accept, s2_load, wr_hs;

    assign req_in = '{req_type: bus.req_type_i, rd: bus.rd_i, rs1: bus.rs1_i, rs2: bus.rs2_i,
                      funct3: bus.funct3_i, funct7: bus.funct7_i, imm: bus.imm_i};

    instr_asm u_asm (
        .req_i  (s1_q),
        .word_o (asm_word),
        .err_o  (asm_err)
    );

    // Elastic two-stage handshake; S1 can refill in the same cycle it drains.
    assign s2_load_ok = !s2_vld_q || bus.wr_ready_i;
    assign s1_adv     = !s1_vld_q || s2_load_ok;
    assign req_ready  = (state_q == ST_RUN) && s1_adv;
    assign accept     = bus.req_valid_i && req_ready;
    assign s2_load    = s1_vld_q && s2_load_ok;
    assign wr_hs      = s2_vld_q && bus.wr_ready_i;

    always_comb begin
        state_d   = state_q;
        s1_d      = s1_q;
        s1_vld_d  = s1_vld_q;
        s2_data_d = s2_data_q;
        s2_vld_d  = s2_vld_q;
        addr_d    = addr_q;
        err_d     = err_q;
        done_d    = 1'b0;

        if (s2_load) begin
            s2_data_d = asm_word;
            s2_vld_d  = 1'b1;
            err_d     = err_q | asm_err;
        end else if (wr_hs) begin
            s2_vld_d  = 1'b0;
        end

        if (accept) begin
            s1_d     = req_in;
            s1_vld_d = 1'b1;
        end else if (s2_load) begin
            s1_vld_d = 1'b0;
        end

        if (wr_hs) addr_d = addr_q + ADDR_W'(4);

        // Start is only honoured in IDLE, where the pipeline is always empty.
        case (state_q)
            ST_IDLE: if (bus.start_i) begin
                state_d = ST_RUN;
                addr_d  = {bus.start_addr_i[ADDR_W-1:2], 2'b00};
                err_d   = 1'b0;
            end
            ST_RUN:   if (bus.stop_i) state_d = ST_DRAIN;
            ST_DRAIN: if (!s1_vld_q && !s2_vld_q) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            s1_q      <= '0;
            s1_vld_q  <= 1'b0;
            s2_data_q <= '0;
            s2_vld_q  <= 1'b0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= s1_d;
            s1_vld_q  <= s1_vld_d;
            s2_data_q <= s2_data_d;
            s2_vld_q  <= s2_vld_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

`ifdef INSTR_ENC_COUNT_EN
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (state_q == ST_IDLE && bus.start_i) count_d = '0;
        else if (wr_hs && count_q != '1)      count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

    assign bus.count_o = count_q;
`else
    assign bus.count_o = '0;
`endif

    assign bus.req_ready_o = req_ready;
    assign bus.wr_valid_o  = s2_vld_q;
    assign bus.wr_data_o   = s2_data_q;
    assign bus.wr_addr_o   = addr_q;
    assign bus.err_o       = err_q;
    assign bus.done_o      = done_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus randomized sessions
// scored against a field-arithmetic reference model and an ordered scoreboard.
module tb_instr_encoder;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned AMOD   = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(.ADDR_W(ADDR_W)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference encoder built from field positions with shifts and masks; bit 32 = error.
    function automatic logic [32:0] ref_enc(input int unsigned t, rd, rs1, rs2, f3, f7, imm);
        int unsigned u, w, base;
        bit e;
        u    = imm & 32'h1fff;
        base = (rs1 << 15) | (f3 << 12);
        e    = 1'b0;
        case (t)
            0: w = (f7 << 25) | (rs2 << 20) | base | (rd << 7) | 32'h33;
            1: begin w = ((u & 32'hfff) << 20) | base | (rd << 7) | 32'h13; e = ((u >> 12) & 1) != ((u >> 11) & 1); end
            2: begin w = ((u & 32'hfff) << 20) | base | (rd << 7) | 32'h03; e = ((u >> 12) & 1) != ((u >> 11) & 1); end
            3: begin
                w = (((u >> 5) & 32'h7f) << 25) | (rs2 << 20) | base | ((u & 32'h1f) << 7) | 32'h23;
                e = ((u >> 12) & 1) != ((u >> 11) & 1);
            end
            4: begin
                w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3f) << 25) | (rs2 << 20) | base
                  | (((u >> 1) & 32'hf) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
                e = (u & 1) != 0;
            end
            default: begin w = 32'h13; e = 1'b1; end
        endcase
        return {e, w};
    endfunction

    // Scoreboard, write log and session model
    logic [31:0] exp_data_q[$];
    int          exp_addr_q[$];
    logic [31:0] log_data[$];
    int          log_addr[$];
    int          model_addr;
    bit          model_err;
    int          model_cnt;
    logic [32:0] mon_r;

    bit   rand_rdy = 1'b0;
    logic forced_rdy = 1'b1;

    always @(posedge clk) begin
        #1;
        bus.wr_ready_i = rand_rdy ? logic'($urandom_range(0, 3) != 0) : forced_rdy;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req_valid_i && bus.req_ready_o) begin
                mon_r = ref_enc(bus.req_type_i, bus.rd_i, bus.rs1_i, bus.rs2_i,
                                bus.funct3_i, bus.funct7_i, bus.imm_i);
                exp_data_q.push_back(mon_r[31:0]);
                exp_addr_q.push_back(model_addr);
                model_addr = (model_addr + 4) % AMOD;
                if (mon_r[32]) model_err = 1'b1;
            end
            if (bus.wr_valid_o && bus.wr_ready_i) begin
                log_data.push_back(bus.wr_data_o);
                log_addr.push_back(int'(bus.wr_addr_o));
                if (exp_data_q.size() == 0) begin
                    chk("wr_unexpected", 32'(bus.wr_valid_o), 32'd0);
                end else begin
                    chk("wr_data", bus.wr_data_o, exp_data_q.pop_front());
                    chk("wr_addr", 32'(bus.wr_addr_o), 32'(exp_addr_q.pop_front()));
                    model_cnt++;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int t, rd, rs1, rs2, f3, f7, imm);
        bus.req_type_i  = 3'(t);
        bus.rd_i        = 5'(rd);
        bus.rs1_i       = 5'(rs1);
        bus.rs2_i       = 5'(rs2);
        bus.funct3_i    = 3'(f3);
        bus.funct7_i    = 7'(f7);
        bus.imm_i       = 13'(imm);
        bus.req_valid_i = 1'b1;
    endtask

    task automatic wait_accept(input string tag);
        int n = 0;
        forever begin
            @(negedge clk);
            if (bus.req_ready_o) break;
            n++;
            if (n > 200) begin
                chk({tag, "_accept_timeout"}, 32'(bus.req_ready_o), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
    endtask

    task automatic send(input string tag, input int t, rd, rs1, rs2, f3, f7, imm);
        drive_req(t, rd, rs1, rs2, f3, f7, imm);
        wait_accept(tag);
    endtask

    task automatic start_session(input int a);
        model_addr = a & (AMOD - 4);
        model_err  = 1'b0;
        model_cnt  = 0;
        log_data.delete();
        log_addr.delete();
        bus.start_i      = 1'b1;
        bus.start_addr_i = ADDR_W'(a);
        @(posedge clk);
        #1 bus.start_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        int nd = 0;
        int cyc = 0;
        while (cyc < 300 && nd == 0) begin
            @(negedge clk);
            if (bus.done_o) nd++;
            cyc++;
        end
        repeat (4) begin
            @(negedge clk);
            if (bus.done_o) nd++;
        end
        @(posedge clk);
        #1;
        chk({tag, "_done_pulses"}, 32'(nd), 32'd1);
        chk({tag, "_pending"}, 32'(exp_data_q.size()), 32'd0);
        chk({tag, "_err"}, 32'(bus.err_o), 32'(model_err));
        chk({tag, "_idle_ready"}, 32'(bus.req_ready_o), 32'd0);
`ifdef INSTR_ENC_COUNT_EN
        chk({tag, "_count"}, 32'(bus.count_o), 32'(model_cnt > 65535 ? 65535 : model_cnt));
`else
        chk({tag, "_count"}, 32'(bus.count_o), 32'd0);
`endif
    endtask

    task automatic end_session(input string tag);
        bus.stop_i = 1'b1;
        @(posedge clk);
        #1 bus.stop_i = 1'b0;
        drain(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrdy, nval, nreq, t, imm;
        rst = 1'b1;
        bus.start_i = 1'b0; bus.start_addr_i = '0; bus.stop_i = 1'b0;
        bus.req_valid_i = 1'b0;
        drive_req(0, 0, 0, 0, 0, 0, 0);
        bus.req_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
        chk("rst_wr_valid",  32'(bus.wr_valid_o),  32'd0);
        chk("rst_wr_addr",   32'(bus.wr_addr_o),   32'd0);
        chk("rst_wr_data",   bus.wr_data_o,        32'd0);
        chk("rst_err",       32'(bus.err_o),       32'd0);
        chk("rst_done",      32'(bus.done_o),      32'd0);
        chk("rst_count",     32'(bus.count_o),     32'd0);
        rst = 1'b0;
        idle(2);

        // R add x3,x1,x2: word appears two edges after acceptance
        start_session(0);
        send("r_add", 0, 3, 1, 2, 0, 0, 0);
        @(negedge clk);
        chk("r_lat_early", 32'(bus.wr_valid_o), 32'd0);
        @(negedge clk);
        chk("r_lat_valid", 32'(bus.wr_valid_o), 32'd1);
        chk("r_lat_data",  bus.wr_data_o, 32'h002081B3);
        chk("r_lat_addr",  32'(bus.wr_addr_o), 32'd0);
        @(posedge clk);
        #1;
        end_session("r_add");

        // addi x1,x0,-1 then sw x5,8(x2)
        start_session(0);
        send("addi", 1, 1, 0, 0, 0, 0, -1);
        send("sw",   3, 0, 2, 5, 2, 0, 8);
        end_session("i_s");
        chk("i_s_nwords", 32'(log_data.size()), 32'd2);
        if (log_data.size() == 2) begin
            chk("addi_data", log_data[0], 32'hFFF00093);
            chk("addi_addr", 32'(log_addr[0]), 32'd0);
            chk("sw_data",   log_data[1], 32'h00512423);
            chk("sw_addr",   32'(log_addr[1]), 32'd4);
        end

        // beq x1,x2,-4, then misaligned branch sets sticky error
        start_session(0);
        send("beq", 4, 0, 1, 2, 0, 0, -4);
        send("beq_odd", 4, 0, 1, 2, 0, 0, 3);
        send("after_err", 0, 4, 5, 6, 0, 0, 0);
        end_session("b");
        chk("b_err_sticky", 32'(bus.err_o), 32'd1);
        if (log_data.size() > 0) chk("beq_data", log_data[0], 32'hFE208EE3);
        start_session(0);
        chk("err_cleared_by_start", 32'(bus.err_o), 32'd0);

        // Backpressure: three back-to-back requests while memory stalls
        forced_rdy = 1'b0;
        idle(1);
        send("bp1", 0, 1, 2, 3, 0, 0, 0);
        send("bp2", 1, 4, 5, 0, 1, 0, 100);
        drive_req(2, 6, 7, 0, 2, 0, 12);
        nrdy = 0; nval = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.req_ready_o) nrdy++;
            if (bus.wr_valid_o) nval++;
        end
        chk("bp_ready_low_cycles", 32'(nrdy), 32'd0);
        chk("bp_valid_held_cycles", 32'(nval), 32'd5);
        forced_rdy = 1'b1;
        wait_accept("bp3");
        end_session("bp");
        chk("bp_nwords", 32'(log_addr.size()), 32'd3);
        if (log_addr.size() == 3) begin
            chk("bp_addr0", 32'(log_addr[0]), 32'd0);
            chk("bp_addr1", 32'(log_addr[1]), 32'd4);
            chk("bp_addr2", 32'(log_addr[2]), 32'd8);
        end
`ifdef INSTR_ENC_COUNT_EN
        chk("bp_count3", 32'(bus.count_o), 32'd3);
`endif

        // Address wrap in a 16-byte window, unaligned start, illegal type
        start_session(13);
        send("wrap0", 1, 2, 3, 0, 0, 0, 5);
        send("wrap1", 0, 2, 3, 4, 0, 32, 0);
        send("illegal", 7, 1, 1, 1, 1, 1, 1);
        end_session("wrap");
        chk("wrap_nwords", 32'(log_addr.size()), 32'd3);
        if (log_addr.size() == 3) begin
            chk("wrap_addr0", 32'(log_addr[0]), 32'd12);
            chk("wrap_addr1", 32'(log_addr[1]), 32'd0);
            chk("wrap_addr2", 32'(log_addr[2]), 32'd4);
            chk("illegal_nop", log_data[2], 32'h00000013);
        end
        chk("illegal_err", 32'(bus.err_o), 32'd1);

        // start+stop together in IDLE: start wins; start in RUN is ignored
        model_addr = 0; model_err = 1'b0; model_cnt = 0;
        log_data.delete(); log_addr.delete();
        bus.start_i = 1'b1; bus.start_addr_i = '0; bus.stop_i = 1'b1;
        @(posedge clk);
        #1 begin bus.start_i = 1'b0; bus.stop_i = 1'b0; end
        @(negedge clk);
        chk("start_wins", 32'(bus.req_ready_o), 32'd1);
        @(posedge clk);
        #1 begin bus.start_i = 1'b1; bus.start_addr_i = ADDR_W'(8); end
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        // Stop coincides with the second accept; both words still drain
        send("fl0", 0, 9, 10, 11, 0, 0, 0);
        drive_req(1, 12, 13, 0, 0, 0, 7);
        bus.stop_i = 1'b1;
        wait_accept("fl1");
        bus.stop_i = 1'b0;
        drain("flight");
        chk("flight_nwords", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) chk("flight_addr0", 32'(log_addr[0]), 32'd0);

        // Randomized sessions under random backpressure
        rand_rdy = 1'b1;
        for (int s = 0; s < 8; s++) begin
            start_session(int'($urandom_range(0, AMOD - 1)));
            nreq = int'($urandom_range(1, 12));
            for (int r = 0; r < nreq; r++) begin
                t   = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
                imm = ($urandom_range(0, 3) != 0) ? ((int'($urandom_range(0, 4095)) << 20) >>> 20)
                                                  : int'($urandom_range(0, 8191));
                if (t == 4 && $urandom_range(0, 3) != 0) imm = imm & ~1;
                send("rnd", t, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 127)), imm);
                idle(int'($urandom_range(0, 2)));
            end
            end_session("rnd");
        end
        rand_rdy = 1'b0;

        // Asynchronous reset with two words stuck in the pipeline
        forced_rdy = 1'b0;
        idle(1);
        start_session(4);
        send("rs0", 0, 1, 1, 1, 0, 0, 0);
        send("rs1", 0, 2, 2, 2, 0, 0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_wr_valid",  32'(bus.wr_valid_o),  32'd0);
        chk("rst_mid_req_ready", 32'(bus.req_ready_o), 32'd0);
        chk("rst_mid_wr_addr",   32'(bus.wr_addr_o),   32'd0);
        exp_data_q.delete();
        exp_addr_q.delete();
        log_data.delete();
        log_addr.delete();
        forced_rdy = 1'b1;
        idle(2);
        rst = 1'b0;
        nval = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.wr_valid_o) nval++;
        end
        chk("rst_no_writes", 32'(nval), 32'd0);
        chk("rst_log_empty", 32'(log_data.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
